// File: rtl/timeout_bank_if.sv
// Command/status bundle for timeout_bank: channel commands in, per-channel
// running/expiry flags and the combined interrupt out.
interface timeout_bank_if #(
   parameter int W = 8,
   parameter int N = 4
);
   localparam int S = (N > 1) ? $clog2(N) : 1;

   logic [S-1:0] sel;
   logic [W-1:0] count;
   logic         periodic;
   logic         put;
   logic         cancel;
   logic         ack;
   logic [N-1:0] active;
   logic [N-1:0] full;
   logic         irq;

   modport master (
      output sel, count, periodic, put, cancel, ack,
      input  active, full, irq
   );

   modport slave (
      input  sel, count, periodic, put, cancel, ack,
      output active, full, irq
   );
endinterface

// File: rtl/timeout_bank.sv
// Bank of N independent down-counting timeout channels sharing one prescaler.
// Each channel can be one-shot or auto-reload; expiry raises a sticky full
// flag per channel and an OR-ed interrupt, both registered.
module timeout_bank #(
   parameter int W   = 8,
   parameter int N   = 4,
   parameter int DIV = 1
) (
   input logic           clock,
   input logic           reset,
   timeout_bank_if.slave bus
);
   localparam int S  = (N > 1) ? $clog2(N) : 1;
   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [S-1:0]  sel_s;
   logic [PW-1:0] presc_q, presc_d;
   logic          tick_s;

   logic [W-1:0]  remaining_q [N];
   logic [W-1:0]  remaining_d [N];
   logic [W-1:0]  period_q    [N];
   logic [W-1:0]  period_d    [N];
   logic [N-1:0]  mode_q,   mode_d;
   logic [N-1:0]  active_q, active_d;
   logic [N-1:0]  full_q,   full_d;
   logic [N-1:0]  expire_s;
   logic          irq_q,    irq_d;

   assign sel_s      = bus.sel;
   assign bus.active = active_q;
   assign bus.full   = full_q;
   assign bus.irq    = irq_q;

   // Free-running prescaler; tick on its terminal count (every clock when DIV=1).
   always_comb begin
      tick_s = (presc_q == PW'(DIV - 1));
      if (tick_s) begin
         presc_d = {PW{1'b0}};
      end else begin
         presc_d = presc_q + PW'(1'b1);
      end
   end

   // Per-channel countdown/expiry, then addressed command overrides.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         remaining_d[i] = remaining_q[i];
         period_d[i]    = period_q[i];
      end
      mode_d   = mode_q;
      active_d = active_q;
      full_d   = full_q;
      expire_s = {N{1'b0}};

      for (int i = 0; i < N; i++) begin
         // Countdown: an expiry is the tick that finds remaining at 1.
         if (active_q[i] && tick_s) begin
            if (remaining_q[i] == W'(1)) begin
               expire_s[i] = 1'b1;
               full_d[i]   = 1'b1;
               if (mode_q[i]) begin
                  remaining_d[i] = period_q[i];
               end else begin
                  active_d[i]    = 1'b0;
                  remaining_d[i] = {W{1'b0}};
               end
            end else if (remaining_q[i] != {W{1'b0}}) begin
               remaining_d[i] = remaining_q[i] - W'(1);
            end else begin
               remaining_d[i] = remaining_q[i];
            end
         end else begin
            remaining_d[i] = remaining_q[i];
         end

         // Commands on the addressed channel; an out-of-range sel matches none.
         // put overrides a same-edge expiry; an expiry overrides ack.
         if (int'(sel_s) == i) begin
            if (bus.put) begin
               if (bus.count != {W{1'b0}}) begin
                  remaining_d[i] = bus.count;
                  period_d[i]    = bus.count;
                  mode_d[i]      = bus.periodic;
                  active_d[i]    = 1'b1;
                  full_d[i]      = 1'b0;
               end else begin
                  // Zero-length timeout expires immediately and never reloads.
                  remaining_d[i] = {W{1'b0}};
                  active_d[i]    = 1'b0;
                  full_d[i]      = 1'b1;
               end
            end else if (bus.cancel) begin
               active_d[i]    = 1'b0;
               remaining_d[i] = {W{1'b0}};
            end else if (bus.ack && !expire_s[i]) begin
               full_d[i] = 1'b0;
            end else begin
               full_d[i] = full_d[i];
            end
         end else begin
            full_d[i] = full_d[i];
         end
      end

      // Interrupt from next-state flags so it moves on the same edge as full.
      irq_d = |full_d;
   end

   // State registers with synchronous reset that discards all running timeouts.
   always_ff @(posedge clock) begin
      if (reset) begin
         presc_q <= {PW{1'b0}};
         for (int i = 0; i < N; i++) begin
            remaining_q[i] <= {W{1'b0}};
            period_q[i]    <= {W{1'b0}};
         end
         mode_q   <= {N{1'b0}};
         active_q <= {N{1'b0}};
         full_q   <= {N{1'b0}};
         irq_q    <= 1'b0;
      end else begin
         presc_q <= presc_d;
         for (int i = 0; i < N; i++) begin
            remaining_q[i] <= remaining_d[i];
            period_q[i]    <= period_d[i];
         end
         mode_q   <= mode_d;
         active_q <= active_d;
         full_q   <= full_d;
         irq_q    <= irq_d;
      end
   end
endmodule

// File: tb/tb_timeout_bank.sv
// Self-checking bench for timeout_bank: directed scenarios plus a randomized
// run checked against a deadline-based reference model (DIV=1 instance), and
// a DIV=4, N=3 instance for prescaled latency and out-of-range select.
module tb_timeout_bank;
   localparam int W  = 8;
   localparam int N  = 4;
   localparam int N4 = 3;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   timeout_bank_if #(.W(W), .N(N))  bus1 ();
   timeout_bank_if #(.W(W), .N(N4)) bus4 ();

   timeout_bank #(.W(W), .N(N), .DIV(1)) dut1 (
      .clock (clock),
      .reset (reset),
      .bus   (bus1)
   );

   timeout_bank #(.W(W), .N(N4), .DIV(4)) dut4 (
      .clock (clock),
      .reset (reset),
      .bus   (bus4)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Reference model for dut1: absolute deadline edge per running channel.
   bit m_active [N];
   bit m_full   [N];
   bit m_per    [N];
   int m_dead   [N];
   int m_period [N];

   function automatic logic [N-1:0] m_active_vec();
      logic [N-1:0] v;
      for (int c = 0; c < N; c++) v[c] = m_active[c];
      return v;
   endfunction

   function automatic logic [N-1:0] m_full_vec();
      logic [N-1:0] v;
      for (int c = 0; c < N; c++) v[c] = m_full[c];
      return v;
   endfunction

   task automatic model_edge();
      bit exp;
      if (reset) begin
         for (int c = 0; c < N; c++) begin
            m_active[c] = 1'b0;
            m_full[c]   = 1'b0;
         end
      end else begin
         for (int c = 0; c < N; c++) begin
            exp = m_active[c] && (m_dead[c] == cyc);
            if (exp) begin
               m_full[c] = 1'b1;
               if (m_per[c]) m_dead[c] = m_dead[c] + m_period[c];
               else          m_active[c] = 1'b0;
            end
            if (int'(bus1.sel) == c) begin
               if (bus1.put) begin
                  if (bus1.count > 0) begin
                     m_dead[c]   = cyc + int'(bus1.count);
                     m_period[c] = int'(bus1.count);
                     m_per[c]    = bus1.periodic;
                     m_active[c] = 1'b1;
                     m_full[c]   = 1'b0;
                  end else begin
                     m_active[c] = 1'b0;
                     m_full[c]   = 1'b1;
                  end
               end else if (bus1.cancel) begin
                  m_active[c] = 1'b0;
               end else if (bus1.ack && !exp) begin
                  m_full[c] = 1'b0;
               end
            end
         end
      end
   endtask

   task automatic set_idle();
      bus1.sel = '0; bus1.count = '0; bus1.periodic = 1'b0;
      bus1.put = 1'b0; bus1.cancel = 1'b0; bus1.ack = 1'b0;
      bus4.sel = '0; bus4.count = '0; bus4.periodic = 1'b0;
      bus4.put = 1'b0; bus4.cancel = 1'b0; bus4.ack = 1'b0;
   endtask

   // One clock: inputs stable across the rising edge, outputs sampled at the falling edge.
   task automatic step();
      @(posedge clock);
      cyc++;
      model_edge();
      @(negedge clock);
      set_idle();
   endtask

   task automatic cmd1(input int s, input string kind, input int c, input bit per);
      bus1.sel = 2'(s); bus1.count = 8'(c); bus1.periodic = per;
      bus1.put = (kind == "put"); bus1.cancel = (kind == "cancel"); bus1.ack = (kind == "ack");
   endtask

   task automatic test_reset();
      reset = 1'b1;
      set_idle();
      step(); step();
      reset = 1'b0;
      n_checks++; if (bus1.active !== 4'b0000) begin n_fail++; $display("FAIL reset_active: got %b want 0000", bus1.active); end
      n_checks++; if (bus1.full !== 4'b0000) begin n_fail++; $display("FAIL reset_full: got %b want 0000", bus1.full); end
      n_checks++; if (bus1.irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", bus1.irq); end
      n_checks++; if ({bus4.active, bus4.full, bus4.irq} !== 7'b0) begin n_fail++; $display("FAIL reset_div4: got %b want 0", {bus4.active, bus4.full, bus4.irq}); end
   endtask

   task automatic test_oneshot();
      cmd1(0, "put", 10, 1'b0);
      step();
      for (int j = 1; j <= 10; j++) begin
         step();
         if (j < 10) begin
            n_checks++; if (bus1.full[0] !== 1'b0 || bus1.active[0] !== 1'b1) begin n_fail++; $display("FAIL oneshot_wait j=%0d: full/active=%b%b want 01", j, bus1.full[0], bus1.active[0]); end
         end else begin
            n_checks++; if ({bus1.full[0], bus1.active[0], bus1.irq} !== 3'b101) begin n_fail++; $display("FAIL oneshot_expire: full/active/irq=%b%b%b want 101", bus1.full[0], bus1.active[0], bus1.irq); end
         end
      end
      cmd1(0, "ack", 0, 1'b0);
      step();
      n_checks++; if ({bus1.full[0], bus1.irq} !== 2'b00) begin n_fail++; $display("FAIL oneshot_ack: full/irq=%b%b want 00", bus1.full[0], bus1.irq); end
   endtask

   task automatic test_periodic();
      logic exp_full;
      cmd1(1, "put", 3, 1'b1);
      step();
      for (int j = 1; j <= 10; j++) begin
         step();
         exp_full = (j % 3 == 0) && (j <= 9);
         n_checks++; if (bus1.full[1] !== exp_full || bus1.active[1] !== 1'b1) begin n_fail++; $display("FAIL periodic j=%0d: full/active=%b%b want %b1", j, bus1.full[1], bus1.active[1], exp_full); end
         if (j % 3 == 0) cmd1(1, "ack", 0, 1'b0);
      end
      cmd1(1, "cancel", 0, 1'b0);
      step();
      n_checks++; if ({bus1.active[1], bus1.full[1]} !== 2'b00) begin n_fail++; $display("FAIL periodic_cancel: active/full=%b%b want 00", bus1.active[1], bus1.full[1]); end
   endtask

   task automatic test_cancel();
      logic exp_full;
      cmd1(2, "put", 30, 1'b0);
      step();
      for (int j = 1; j <= 40; j++) begin
         if (j == 20) cmd1(2, "cancel", 0, 1'b0);
         if (j == 25) cmd1(2, "put", 11, 1'b0);
         step();
         exp_full = (j >= 36);
         n_checks++; if (bus1.full[2] !== exp_full) begin n_fail++; $display("FAIL cancel_full j=%0d: got %b want %b", j, bus1.full[2], exp_full); end
         if (j >= 20 && j < 25) begin
            n_checks++; if (bus1.active[2] !== 1'b0) begin n_fail++; $display("FAIL cancel_active j=%0d: got %b want 0", j, bus1.active[2]); end
         end
      end
      cmd1(2, "ack", 0, 1'b0);
      step();
   endtask

   task automatic test_zero_and_ack();
      cmd1(3, "put", 0, 1'b1);
      step();
      n_checks++; if ({bus1.full[3], bus1.active[3], bus1.irq} !== 3'b101) begin n_fail++; $display("FAIL zero_put: full/active/irq=%b%b%b want 101", bus1.full[3], bus1.active[3], bus1.irq); end
      step();
      n_checks++; if (bus1.active[3] !== 1'b0) begin n_fail++; $display("FAIL zero_noreload: active=%b want 0", bus1.active[3]); end
      cmd1(3, "ack", 0, 1'b0);
      step();
      n_checks++; if (bus1.full[3] !== 1'b0) begin n_fail++; $display("FAIL zero_ack: full=%b want 0", bus1.full[3]); end
      cmd1(0, "put", 4, 1'b0);
      step();
      for (int j = 1; j <= 3; j++) begin
         step();
         n_checks++; if (bus1.full[0] !== 1'b0) begin n_fail++; $display("FAIL ackexp_wait j=%0d: full=%b want 0", j, bus1.full[0]); end
      end
      cmd1(0, "ack", 0, 1'b0);
      step();
      n_checks++; if (bus1.full[0] !== 1'b1) begin n_fail++; $display("FAIL ack_vs_expiry: full=%b want 1", bus1.full[0]); end
      cmd1(0, "ack", 0, 1'b0);
      step();
      n_checks++; if (bus1.full[0] !== 1'b0) begin n_fail++; $display("FAIL ack_after: full=%b want 0", bus1.full[0]); end
   endtask

   task automatic test_reset_midrun();
      cmd1(0, "put", 8, 1'b0);
      step();
      cmd1(1, "put", 2, 1'b0);
      step();
      step();
      step();
      n_checks++; if (bus1.full[1] !== 1'b1 || bus1.active[0] !== 1'b1) begin n_fail++; $display("FAIL midrun_pre: full1/active0=%b%b want 11", bus1.full[1], bus1.active[0]); end
      cmd1(0, "ack", 0, 1'b0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      n_checks++; if ({bus1.active, bus1.full, bus1.irq} !== 9'b0) begin n_fail++; $display("FAIL midrun_reset: got %b want 0", {bus1.active, bus1.full, bus1.irq}); end
      for (int j = 1; j <= 20; j++) begin
         step();
         n_checks++; if ({bus1.active, bus1.full, bus1.irq} !== 9'b0) begin n_fail++; $display("FAIL midrun_quiet j=%0d: got %b want 0", j, {bus1.active, bus1.full, bus1.irq}); end
      end
   endtask

   task automatic test_div4();
      int rise;
      // Out-of-range select on the 3-channel instance is ignored.
      bus4.sel = 2'd3; bus4.count = 8'd1; bus4.put = 1'b1;
      step();
      for (int j = 1; j <= 8; j++) begin
         step();
         n_checks++; if ({bus4.active, bus4.full, bus4.irq} !== 7'b0) begin n_fail++; $display("FAIL div4_badsel j=%0d: got %b want 0", j, {bus4.active, bus4.full, bus4.irq}); end
      end
      bus4.sel = 2'd0; bus4.count = 8'd2; bus4.put = 1'b1;
      step();
      rise = 0;
      for (int j = 1; j <= 12 && rise == 0; j++) begin
         step();
         if (bus4.full[0] === 1'b1) rise = j;
      end
      n_checks++; if (rise < 5 || rise > 8) begin n_fail++; $display("FAIL div4_latency: rise after %0d clocks want 5..8", rise); end
      // Ticks now fall on every 4th edge from the rise; re-put lands on the expiry edge.
      bus4.sel = 2'd0; bus4.count = 8'd2; bus4.put = 1'b1;
      step();
      n_checks++; if (bus4.full[0] !== 1'b0) begin n_fail++; $display("FAIL div4_reput: full=%b want 0", bus4.full[0]); end
      for (int j = 2; j <= 16; j++) begin
         if (j == 8) begin bus4.sel = 2'd0; bus4.count = 8'd2; bus4.put = 1'b1; end
         step();
         n_checks++; if (bus4.full[0] !== (j == 16)) begin n_fail++; $display("FAIL div4_restart r+%0d: full=%b want %b", j, bus4.full[0], (j == 16)); end
      end
   endtask

   task automatic test_random();
      int r;
      for (int t = 0; t < 400; t++) begin
         r = $urandom_range(0, 9);
         if (r <= 1)      cmd1($urandom_range(0, N - 1), "put", $urandom_range(0, 6), 1'($urandom_range(0, 1)));
         else if (r == 2) cmd1($urandom_range(0, N - 1), "cancel", 0, 1'b0);
         else if (r <= 4) cmd1($urandom_range(0, N - 1), "ack", 0, 1'b0);
         reset = ($urandom_range(0, 149) == 0);
         step();
         reset = 1'b0;
         n_checks++; if (bus1.active !== m_active_vec() || bus1.full !== m_full_vec() || bus1.irq !== (|m_full_vec())) begin
            n_fail++;
            $display("FAIL random t=%0d: active/full/irq=%b/%b/%b want %b/%b/%b", t, bus1.active, bus1.full, bus1.irq, m_active_vec(), m_full_vec(), |m_full_vec());
         end
      end
   endtask

   initial begin
      for (int c = 0; c < N; c++) begin
         m_active[c] = 1'b0; m_full[c] = 1'b0; m_per[c] = 1'b0;
         m_dead[c] = 0; m_period[c] = 0;
      end
      test_reset();
      test_oneshot();
      test_periodic();
      test_cancel();
      test_zero_and_ack();
      test_reset_midrun();
      test_div4();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
